dmem_arbiter: RTL and testbench

Two-way arbiter that shares the single-port data RAM between the single-cycle CPU load/store path and an external debug/program-loader port. The CPU owns the RAM by default. A debug request wins a one-cycle memory slot, and the CPU is stalled for exactly that cycle. The block sits between the memory stage, the debug port and the DRam instance (asynchronous read, synchronous write), in place of the direct memory-stage-to-DRam connection.

---
 rtl/dmem_arbiter.sv | 101 ++++++++++
 tb/tb_dmem_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU memory stage and a debug/loader port.
// The CPU owns the RAM by default; a debug request takes one stalled cycle and is then acknowledged.
module dmem_arbiter #(
  parameter int ADDR_W         = 10,
  parameter int CPU_MIN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_CpuAddr_32,
  input  logic [31:0]       i_CpuWData_32,
  input  logic              i_CpuWe_1,
  output logic [31:0]       o_CpuRData_32,
  output logic              o_CpuStall_1,
  input  logic              i_DbgReq_1,
  input  logic              i_DbgWe_1,
  input  logic [31:0]       i_DbgAddr_32,
  input  logic [31:0]       i_DbgWData_32,
  output logic              o_DbgAck_1,
  output logic [31:0]       o_DbgRData_32,
  output logic [ADDR_W-1:0] o_MemAddr_N,
  output logic [31:0]       o_MemWData_32,
  output logic              o_MemWe_1,
  input  logic [31:0]       i_MemRData_32
);

  typedef enum logic [1:0] {
    ST_CPU = 2'd0,
    ST_DBG = 2'd1,
    ST_ACK = 2'd2
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(CPU_MIN_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  gap_q, gap_d;
  logic [31:0] dbg_rdata_q;

  // Byte-offset bits and bits above the RAM window are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_CpuAddr_32[31:ADDR_W+2], i_CpuAddr_32[1:0],
                              i_DbgAddr_32[31:ADDR_W+2], i_DbgAddr_32[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CPU;
      gap_q       <= 4'd0;
      dbg_rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      if (state_q == ST_DBG) begin
        dbg_rdata_q <= i_MemRData_32;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CPU:  if (i_DbgReq_1 && (gap_q == 4'd0)) state_d = ST_DBG;
      ST_DBG:  state_d = ST_ACK;
      ST_ACK:  state_d = ST_CPU;
      default: state_d = ST_CPU;
    endcase
  end

  // Only DBG leads into ACK, so leaving DBG is the load point for the fairness gap.
  always_comb begin
    gap_d = gap_q;
    if (state_q == ST_DBG) begin
      gap_d = GAP_LOAD;
    end else if (gap_q != 4'd0) begin
      gap_d = gap_q - 4'd1;
    end
  end

  always_comb begin
    o_CpuStall_1  = 1'b0;
    o_DbgAck_1    = 1'b0;
    o_MemAddr_N   = i_CpuAddr_32[ADDR_W+1:2];
    o_MemWData_32 = i_CpuWData_32;
    o_MemWe_1     = i_CpuWe_1;
    case (state_q)
      ST_DBG: begin
        o_CpuStall_1  = 1'b1;
        o_MemAddr_N   = i_DbgAddr_32[ADDR_W+1:2];
        o_MemWData_32 = i_DbgWData_32;
        o_MemWe_1     = i_DbgWe_1;
      end
      ST_ACK:  o_DbgAck_1 = 1'b1;
      default: ;
    endcase
    if (rst) begin
      o_MemWe_1 = 1'b0;
    end
  end

  assign o_CpuRData_32 = i_MemRData_32;
  assign o_DbgRData_32 = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural RAM (async read, sync write).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dmem_arbiter;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata;
  logic              cpu_we, cpu_stall;
  logic              dbg_req, dbg_we, dbg_ack;
  logic [31:0]       dbg_addr, dbg_wdata, dbg_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              mem_we;
  logic              ram_clr;

  logic [31:0] ram [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < (1<<ADDR_W); i++) ram[i] <= 32'd0;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = ram[mem_addr];

  dmem_arbiter #(.ADDR_W(ADDR_W), .CPU_MIN_CYCLES(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_CpuAddr_32  (cpu_addr),
    .i_CpuWData_32 (cpu_wdata),
    .i_CpuWe_1     (cpu_we),
    .o_CpuRData_32 (cpu_rdata),
    .o_CpuStall_1  (cpu_stall),
    .i_DbgReq_1    (dbg_req),
    .i_DbgWe_1     (dbg_we),
    .i_DbgAddr_32  (dbg_addr),
    .i_DbgWData_32 (dbg_wdata),
    .o_DbgAck_1    (dbg_ack),
    .o_DbgRData_32 (dbg_rdata),
    .o_MemAddr_N   (mem_addr),
    .o_MemWData_32 (mem_wdata),
    .o_MemWe_1     (mem_we),
    .i_MemRData_32 (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge with the gap counter at zero; returns on the falling edge of the ack cycle.
  task automatic dbg_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] exp_word);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = data;
    #1 check("pre_stall", {31'd0, cpu_stall}, 32'd0);
    @(negedge clk);
    check("dbg_stall", {31'd0, cpu_stall}, 32'd1);
    check("dbg_ack0", {31'd0, dbg_ack}, 32'd0);
    check("dbg_addr", {22'd0, mem_addr}, exp_word);
    check("dbg_we", {31'd0, mem_we}, {31'd0, we});
    if (we) check("dbg_wdata", mem_wdata, data);
    @(negedge clk);
    check("ack_stall", {31'd0, cpu_stall}, 32'd0);
    check("ack", {31'd0, dbg_ack}, 32'd1);
    if (we) check("ram_wr", ram[exp_word[ADDR_W-1:0]], data);
    else    check("dbg_rdata", dbg_rdata, data);
    $display("TXN we=%0d addr=%h data=%h word=%0d", we, addr, data, exp_word);
    dbg_req = 1'b0;
  endtask

  logic [14:0] stall_pat;
  logic [14:0] ack_pat;

  initial begin
    stall_pat = 15'b100001000010000;
    ack_pat   = 15'b010000100001000;
    rst = 1'b1; ram_clr = 1'b1;
    cpu_addr = 32'h40; cpu_wdata = 32'h55; cpu_we = 1'b1;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'd0; dbg_wdata = 32'd0;

    // Reset held two cycles with a CPU store pending
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ram_clr = 1'b0;
      check("rst_memwe", {31'd0, mem_we}, 32'd0);
    end
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_ack", {31'd0, dbg_ack}, 32'd0);
    check("rst_rdata", dbg_rdata, 32'd0);
    rst = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    check("post_rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("post_rst_ack", {31'd0, dbg_ack}, 32'd0);
    check("post_rst_rdata", dbg_rdata, 32'd0);
    check("ram16_untouched", ram[16], 32'd0);

    // Debug write then read back
    dbg_txn(1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'd4);
    idle(4);
    dbg_txn(1'b0, 32'h0000_0010, 32'hDEADBEEF, 32'd4);
    @(negedge clk);
    check("rdata_held", dbg_rdata, 32'hDEADBEEF);
    check("held_ack0", {31'd0, dbg_ack}, 32'd0);
    idle(3);

    // Collision: CPU keeps storing to the same word during the debug write
    cpu_addr = 32'h10; cpu_wdata = 32'h11111111; cpu_we = 1'b1;
    dbg_txn(1'b1, 32'h0000_0010, 32'h22222222, 32'd4);
    @(negedge clk);
    check("coll_cpu_after", ram[4], 32'h11111111);
    cpu_we = 1'b0;
    idle(3);

    // Fairness: request held continuously with CPU_MIN_CYCLES = 3
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check($sformatf("fair_stall%0d", k), {31'd0, cpu_stall}, {31'd0, stall_pat[14-k]});
      check($sformatf("fair_ack%0d", k), {31'd0, dbg_ack}, {31'd0, ack_pat[14-k]});
    end
    $display("TXN fairness run: 15 cycles with req held");
    dbg_req = 1'b0;
    idle(4);

    // Reset during the DBG cycle of a write
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'hCAFEF00D;
    @(negedge clk);
    check("rmid_stall", {31'd0, cpu_stall}, 32'd1);
    check("rmid_we_pre", {31'd0, mem_we}, 32'd1);
    rst = 1'b1; dbg_req = 1'b0;
    #1 check("rmid_we_forced", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    check("rmid_ack", {31'd0, dbg_ack}, 32'd0);
    check("rmid_state", {31'd0, cpu_stall}, 32'd0);
    check("rmid_ram8", ram[8], 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rmid_ack2", {31'd0, dbg_ack}, 32'd0);
    check("rmid_ram8b", ram[8], 32'd0);
    $display("TXN reset abort addr=00000020");

    // Address wrap: bits above the RAM window are ignored
    dbg_txn(1'b1, 32'h0000_1004, 32'hA5A55A5A, 32'd1);
    @(negedge clk);
    check("wrap_ram1", ram[1], 32'hA5A55A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
